// File: rtl/seq_sched_pkg.sv
// -----------------------------------------------------------------------------
// seq_sched_pkg
// Shared constants for the time-shared "1 then 0" sequence detector.
//   ST_W   : width of one channel's detector state
//   HIT_W  : width of one per-channel detect counter (optional feature)
//   S_IDLE : nothing useful seen yet
//   S_1    : last relevant bit was a 1
//   S_10   : a 1 followed by one or more 0s has been seen (detect state)
// -----------------------------------------------------------------------------
package seq_sched_pkg;

    localparam int ST_W  = 2;
    localparam int HIT_W = 8;

    localparam logic [ST_W-1:0] S_IDLE = 2'b00;
    localparam logic [ST_W-1:0] S_1    = 2'b01;
    localparam logic [ST_W-1:0] S_10   = 2'b10;

endpackage

// File: rtl/seq_step.sv
// -----------------------------------------------------------------------------
// seq_step
// Purely combinational step of the "1 then 0" detector. One instance is shared
// by all channels; the caller muxes in the granted channel's state and bit.
// Ports:
//   state      in  ST_W  current state of the granted channel
//   serial_bit in  1     incoming serial bit
//   next_state out ST_W  state after consuming serial_bit
//   hit        out 1     next_state is the detect state S_10
// -----------------------------------------------------------------------------
module seq_step
    import seq_sched_pkg::*;
(
    input  logic [ST_W-1:0] state,
    input  logic            serial_bit,
    output logic [ST_W-1:0] next_state,
    output logic            hit
);

    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE:  next_state = serial_bit ? S_1    : S_IDLE;
            S_1:     next_state = serial_bit ? S_1    : S_10;
            S_10:    next_state = serial_bit ? S_IDLE : S_10;
            // The unused code recovers to idle, so hit stays low.
            default: next_state = S_IDLE;
        endcase
    end

    assign hit = (next_state == S_10);

endmodule

// File: rtl/seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// seq_detect_scheduler
// Time-shares one seq_step engine among NCH serial bit channels. Each channel's
// detector state lives in a small register file; a round-robin arbiter grants
// one eligible channel per cycle and the result appears one cycle later,
// tagged with the channel id.
// Optional feature macro: SEQ_SCHED_HITCNT_EN adds per-channel saturating
// 8-bit detect counters on output hit_cnt.
// Ports:
//   clk        in  1        rising-edge clock
//   rst_n      in  1        asynchronous active-low reset
//   req_valid  in  NCH      channel i has a bit to process
//   req_bit    in  NCH      serial bit of channel i
//   req_ready  out NCH      one-hot grant (combinational)
//   clr        in  NCH      synchronous per-channel state clear
//   out_valid  out 1        result of last cycle's grant
//   out_ch     out CHW      channel id of the result
//   out1       out 1        detect flag of the result
//   hit_cnt    out 8*NCH    per-channel detect counters (macro only)
// -----------------------------------------------------------------------------
module seq_detect_scheduler
    import seq_sched_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH-1:0]     req_valid,
    input  logic [NCH-1:0]     req_bit,
    output logic [NCH-1:0]     req_ready,
    input  logic [NCH-1:0]     clr,
    output logic               out_valid,
    output logic [CHW-1:0]     out_ch,
    output logic               out1
`ifdef SEQ_SCHED_HITCNT_EN
    ,
    output logic [HIT_W*NCH-1:0] hit_cnt
`endif
);

    logic [NCH-1:0]  eligible;
    logic            grant_any;
    logic [CHW-1:0]  grant_ch;
    logic [CHW-1:0]  ptr_reg;
    logic [CHW-1:0]  ptr_next;
    logic [ST_W-1:0] state_reg [NCH];
    logic [ST_W-1:0] cur_state;
    logic            cur_bit;
    logic [ST_W-1:0] step_state;
    logic            step_hit;

    // A channel being cleared this cycle is never granted.
    assign eligible = req_valid & ~clr;

    // Round-robin search starting at ptr_reg. The sum is one bit wider than
    // the id so the wrap works for channel counts that are not powers of two.
    always_comb begin
        logic [CHW:0]   sum;
        logic [CHW-1:0] idx;
        grant_any = 1'b0;
        grant_ch  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, ptr_reg} + (CHW+1)'(k);
            if (sum >= (CHW+1)'(NCH)) begin
                sum = sum - (CHW+1)'(NCH);
            end
            idx = sum[CHW-1:0];
            if (!grant_any && eligible[idx]) begin
                grant_any = 1'b1;
                grant_ch  = idx;
            end
        end
    end

    assign req_ready = grant_any ? (NCH'(1) << grant_ch) : '0;
    assign ptr_next  = (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + 1'b1;

    assign cur_state = state_reg[grant_ch];
    assign cur_bit   = req_bit[grant_ch];

    seq_step u_step (
        .state      (cur_state),
        .serial_bit (cur_bit),
        .next_state (step_state),
        .hit        (step_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out1      <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state_reg[i] <= S_IDLE;
            end
        end else begin
            out_valid <= grant_any;
            // out_ch/out1 keep the last result while idle.
            if (grant_any) begin
                ptr_reg <= ptr_next;
                out_ch  <= grant_ch;
                out1    <= step_hit;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    state_reg[i] <= S_IDLE;
                end else if (grant_any && (grant_ch == CHW'(i))) begin
                    state_reg[i] <= step_state;
                end
            end
        end
    end

`ifdef SEQ_SCHED_HITCNT_EN
    logic [HIT_W-1:0] hit_cnt_reg [NCH];

    // Counted at the grant edge, so the count moves together with out1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                hit_cnt_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (clr[i]) begin
                    hit_cnt_reg[i] <= '0;
                end else if (grant_any && (grant_ch == CHW'(i)) && step_hit
                             && (hit_cnt_reg[i] != '1)) begin
                    hit_cnt_reg[i] <= hit_cnt_reg[i] + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_hit_out
        assign hit_cnt[gi*HIT_W +: HIT_W] = hit_cnt_reg[gi];
    end
`endif

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_scheduler
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against a channel-level behavioural model. Also exercises a
// standalone seq_step for the unused state code. Honors SEQ_SCHED_HITCNT_EN.
// -----------------------------------------------------------------------------
module tb_seq_detect_scheduler;

    localparam int NCH = 4;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_bit;
    logic [NCH-1:0] req_ready;
    logic [NCH-1:0] clr;
    logic           out_valid;
    logic [CHW-1:0] out_ch;
    logic           out1;
`ifdef SEQ_SCHED_HITCNT_EN
    logic [8*NCH-1:0] hit_cnt;
`endif

    logic [1:0] ts_state;
    logic       ts_bit;
    logic [1:0] ts_next;
    logic       ts_hit;

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-channel phase 0 = nothing, 1 = holding a '1',
    // 2 = have seen '1' then '0' (detecting).
    int m_phase [NCH];
    int m_cnt   [NCH];
    int m_ptr;
    bit m_valid;
    int m_ch;
    bit m_out1;
    bit pend     [NCH];
    bit pend_bit [NCH];

    seq_detect_scheduler #(.NCH(NCH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out1      (out1)
`ifdef SEQ_SCHED_HITCNT_EN
        ,
        .hit_cnt   (hit_cnt)
`endif
    );

    seq_step u_step_ref (
        .state      (ts_state),
        .serial_bit (ts_bit),
        .next_state (ts_next),
        .hit        (ts_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int detect_next(input int ph, input bit b);
        if (ph == 0) return b ? 1 : 0;
        if (ph == 1) return b ? 1 : 2;
        if (ph == 2) return b ? 0 : 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_phase[i]  = 0;
            m_cnt[i]    = 0;
            pend[i]     = 1'b0;
            pend_bit[i] = 1'b0;
        end
        m_ptr   = 0;
        m_valid = 1'b0;
        m_ch    = 0;
        m_out1  = 1'b0;
    endtask

    // Entered and left at posedge+1. Channels with an unconsumed bit keep
    // requesting with the same bit regardless of the requested v/b.
    task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                        input logic [NCH-1:0] c);
        logic [NCH-1:0] vv;
        logic [NCH-1:0] bb;
        logic [NCH-1:0] exp_ready;
        int g;
        int ns;
        vv = v;
        bb = b;
        for (int i = 0; i < NCH; i++) begin
            if (pend[i]) begin
                vv[i] = 1'b1;
                bb[i] = pend_bit[i];
            end
        end
        req_valid = vv;
        req_bit   = bb;
        clr       = c;
        #3;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (m_ptr + k) % NCH;
            if (g < 0 && vv[idx] && !c[idx]) g = idx;
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        for (int i = 0; i < NCH; i++) begin
            if (c[i]) begin
                m_phase[i] = 0;
                m_cnt[i]   = 0;
            end
        end
        if (g >= 0) begin
            ns         = detect_next(m_phase[g], bb[g]);
            m_phase[g] = ns;
            m_valid    = 1'b1;
            m_ch       = g;
            m_out1     = (ns == 2);
            if (m_out1 && m_cnt[g] < 255) m_cnt[g]++;
            m_ptr = (g + 1) % NCH;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < NCH; i++) begin
            pend[i]     = vv[i] && (i != g);
            pend_bit[i] = bb[i];
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_ch", out_ch, m_ch);
        check("out1", out1, m_out1);
`ifdef SEQ_SCHED_HITCNT_EN
        for (int i = 0; i < NCH; i++) begin
            check("hit_cnt", hit_cnt[i*8 +: 8], m_cnt[i]);
        end
`endif
        if (g >= 0) $display("txn ch=%0d bit=%0d out1=%0d", g, bb[g], out1);
    endtask

    // Entered at posedge+1; asserts reset between edges and checks the
    // outputs drop without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_out1", out1, 0);
`ifdef SEQ_SCHED_HITCNT_EN
        check("rst_hit_cnt", hit_cnt, 0);
`endif
        model_reset();
        req_valid = '0;
        req_bit   = '0;
        clr       = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("txn reset");
    endtask

    logic [5:0] t2_bits;
    logic [5:0] t2_hits;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_bit   = '0;
        clr       = '0;
        ts_state  = 2'b00;
        ts_bit    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // 1. Reset mid-stream while a result is valid
        step(4'b0001, 4'b0001, 4'b0000);
        check("t1_valid_before_reset", out_valid, 1);
        do_reset();
        step(4'b0001, 4'b0001, 4'b0000);
        check("t1_out1_after_reset", out1, 0);
        step(4'b0001, 4'b0000, 4'b0000);
        check("t1_state_was_s1", out1, 1);

        // 2. Channel 2 streams 1,0,0,1,1,0 (index 0 first)
        t2_bits = 6'b011001;
        t2_hits = 6'b100110;
        for (int k = 0; k < 6; k++) begin
            step(4'b0100, t2_bits[k] ? 4'b0100 : 4'b0000, 4'b0000);
            check("t2_ch", out_ch, 2);
            check("t2_out1", out1, t2_hits[k]);
        end

        // 3. All channels valid: strict rotation starting at channel 0
        step(4'b1000, 4'($urandom), 4'b0000);   // leaves the pointer at 0
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 4'($urandom), 4'b0000);
            check("t3_order", out_ch, k % NCH);
        end
        for (int k = 0; k < NCH; k++) step(4'b0000, 4'b0000, 4'b0000);

        // 4. Clear collides with a request on channel 1
        step(4'b0000, 4'b0000, 4'b0010);
        step(4'b0010, 4'b0010, 4'b0000);
        step(4'b0010, 4'b0000, 4'b0010);
        check("t4_ready1_low", req_ready[1], 0);
        step(4'b0000, 4'b0000, 4'b0000);
        check("t4_ch", out_ch, 1);
        check("t4_out1", out1, 0);

        // 5. Unused state code recovers to idle without a hit
        ts_state = 2'b11; ts_bit = 1'b1; #1;
        check("t5_next_b1", ts_next, 0);
        check("t5_hit_b1", ts_hit, 0);
        ts_state = 2'b11; ts_bit = 1'b0; #1;
        check("t5_next_b0", ts_next, 0);
        check("t5_hit_b0", ts_hit, 0);
        ts_state = 2'b01; ts_bit = 1'b0; #1;
        check("t5_s1_b0", {ts_next, ts_hit}, 3'b101);
        @(posedge clk);
        #1;

        // Randomized traffic with occasional clears
        for (int n = 0; n < 500; n++) begin
            logic [NCH-1:0] cm;
            cm = '0;
            for (int i = 0; i < NCH; i++) cm[i] = ($urandom_range(0, 9) == 0);
            step(4'($urandom), 4'($urandom), cm);
        end
        do_reset();

`ifdef SEQ_SCHED_HITCNT_EN
        // 6. Counter saturation and clear on channel 0
        step(4'b0001, 4'b0001, 4'b0000);
        for (int n = 0; n < 300; n++) step(4'b0001, 4'b0000, 4'b0000);
        check("t6_saturated", hit_cnt[7:0], 255);
        step(4'b0000, 4'b0000, 4'b0001);
        check("t6_cleared", hit_cnt[7:0], 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
